// File: rtl/ps2_pkg.sv
// Shared constants, decoder state encoding and parity helper for the PS/2 key tracker.
package ps2_pkg;

  localparam int unsigned KEY_IDX_W = 9;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_state_e;

  // Keyboard status/ack bytes that are not key codes and cancel any pending prefix.
  function automatic logic is_ctrl_code(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, falling-edge
// detect, 11-bit frame shift, odd-parity/stop check and inter-bit timeout.
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        clk_sync_q, clk_sync_d;
  logic [1:0]        data_sync_q, data_sync_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              filt_lvl_q, filt_lvl_d;
  logic              filt_prev_q, filt_prev_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              fall_s;
  logic              data_s;

  assign fall_s = filt_prev_q & ~filt_lvl_q;
  assign data_s = data_sync_q[1];

  // Synchronizers and the ps2_clk level filter.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filt_prev_d = filt_lvl_q;
    filt_lvl_d  = filt_lvl_q;
    filt_cnt_d  = '0;
    if (clk_sync_q[1] != filt_lvl_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_lvl_d = clk_sync_q[1];
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_W'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  // Frame bit sequencing, checks and timeout.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (fall_s) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          // A high start bit means we joined mid-stream; wait for a real start.
          if (!data_s) begin
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
          end
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        4'd9: begin
          par_d     = data_s;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: bit_cnt_d = 4'd0;
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // State registers; the idle PS/2 bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_cnt_q  <= '0;
      filt_lvl_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      byte_q      <= 8'h00;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_lvl_q  <= filt_lvl_d;
      filt_prev_q <= filt_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign byte_data  = byte_q;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 decoder maintaining a 512-bit held-key bitmap.
// Optional macro PS2_TYPEMATIC_SUPPRESS_EN: repeated makes of a held key are ignored.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [511:0]         key_down,
  output logic [KEY_IDX_W-1:0] last_change,
  output logic                 been_ready,
  output logic                 frame_err
);

  logic [7:0]           rx_byte_s;
  logic                 rx_valid_s;
  logic                 rx_err_s;
  dec_state_e           state_q, state_d;
  logic [511:0]         key_down_q, key_down_d;
  logic [KEY_IDX_W-1:0] last_change_q, last_change_d;
  logic                 been_ready_q, been_ready_d;
  logic                 frame_err_q, frame_err_d;
  logic                 ext_s, brk_s, suppress_s;
  logic [KEY_IDX_W-1:0] idx_s;

  ps2_byte_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (rx_byte_s),
    .byte_valid(rx_valid_s),
    .byte_err  (rx_err_s)
  );

  // Pending prefix flags implied by the decoder state.
  always_comb begin
    ext_s = 1'b0;
    brk_s = 1'b0;
    case (state_q)
      ST_E0:   ext_s = 1'b1;
      ST_F0:   brk_s = 1'b1;
      ST_E0F0: begin
        ext_s = 1'b1;
        brk_s = 1'b1;
      end
      default: begin
        ext_s = 1'b0;
        brk_s = 1'b0;
      end
    endcase
  end

  assign idx_s = {ext_s, rx_byte_s};

`ifdef PS2_TYPEMATIC_SUPPRESS_EN
  assign suppress_s = ~brk_s & key_down_q[idx_s];
`else
  assign suppress_s = 1'b0;
`endif

  // Byte decoder: prefix tracking, bitmap update and strobes.
  always_comb begin
    state_d       = state_q;
    key_down_d    = key_down_q;
    last_change_d = last_change_q;
    been_ready_d  = 1'b0;
    frame_err_d   = 1'b0;
    if (rx_err_s) begin
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end else if (rx_valid_s) begin
      if (rx_byte_s == PS2_EXT) begin
        case (state_q)
          ST_IDLE: state_d = ST_E0;
          ST_F0:   state_d = ST_E0F0;
          default: state_d = state_q;
        endcase
      end else if (rx_byte_s == PS2_BRK) begin
        case (state_q)
          ST_IDLE: state_d = ST_F0;
          ST_E0:   state_d = ST_E0F0;
          default: state_d = state_q;
        endcase
      end else if (rx_byte_s == PS2_PAUSE) begin
        state_d = state_q;
      end else if (is_ctrl_code(rx_byte_s)) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_IDLE;
        if (!suppress_s) begin
          key_down_d[idx_s] = ~brk_s;
          last_change_d     = idx_s;
          been_ready_d      = 1'b1;
        end else begin
          been_ready_d = 1'b0;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // Decoder FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      key_down_q    <= '0;
      last_change_q <= '0;
      been_ready_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_down_q    <= key_down_d;
      last_change_q <= last_change_d;
      been_ready_q  <= been_ready_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign key_down    = key_down_q;
  assign last_change = last_change_q;
  assign been_ready  = been_ready_q;
  assign frame_err   = frame_err_q;

endmodule
